// File: rtl/rot_arb_pkg.sv
// Shared widths and types for the two-requester rotate-right arbiter.
package rot_arb_pkg;

   localparam int DATA_W  = 8;
   localparam int SHAMT_W = 3;

   // Index of a requester (0 or 1).
   typedef logic req_id_t;

   // Occupancy of the single response slot.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage : rot_arb_pkg

// File: rtl/rotate_arbiter_if.sv
// Bundle of both requester ports and the response port.
// The slave modport is the arbiter; the master modport drives the
// requesters and consumes the response.
interface rotate_arbiter_if;
   import rot_arb_pkg::*;

   logic                req0_valid;
   logic                req0_ready;
   logic [DATA_W-1:0]   req0_d_in;
   logic [SHAMT_W-1:0]  req0_n_bits;

   logic                req1_valid;
   logic                req1_ready;
   logic [DATA_W-1:0]   req1_d_in;
   logic [SHAMT_W-1:0]  req1_n_bits;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_d_out;
   req_id_t             rsp_id;

   modport slave (
      input  req0_valid, req0_d_in, req0_n_bits,
      input  req1_valid, req1_d_in, req1_n_bits,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_d_out, rsp_id
   );

   modport master (
      output req0_valid, req0_d_in, req0_n_bits,
      output req1_valid, req1_d_in, req1_n_bits,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_d_out, rsp_id
   );

endinterface : rotate_arbiter_if

// File: rtl/rotr8.sv
// Combinational 8-bit rotate right as a 1/2/4 log shifter.
module rotr8
   import rot_arb_pkg::*;
(
   input  logic [DATA_W-1:0]  d_in,
   input  logic [SHAMT_W-1:0] n_bits,
   output logic [DATA_W-1:0]  d_out
);

   logic [DATA_W-1:0] stage1;
   logic [DATA_W-1:0] stage2;

   // Each stage rotates by its power of two when the matching amount bit is set.
   always_comb begin
      stage1 = d_in;
      stage2 = d_in;
      d_out  = d_in;
      if (n_bits[0]) begin
         stage1 = {d_in[0], d_in[7:1]};
      end else begin
         stage1 = d_in;
      end
      if (n_bits[1]) begin
         stage2 = {stage1[1:0], stage1[7:2]};
      end else begin
         stage2 = stage1;
      end
      if (n_bits[2]) begin
         d_out = {stage2[3:0], stage2[7:4]};
      end else begin
         d_out = stage2;
      end
   end

endmodule : rotr8

// File: rtl/rotate_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath between two
// requesters, feeding a single registered response slot.
module rotate_arbiter
   import rot_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   rotate_arbiter_if.slave  bus
);

   slot_state_t        state_q;
   slot_state_t        state_d;
   req_id_t            last_grant_q;
   req_id_t            last_grant_d;
   logic [DATA_W-1:0]  rsp_data_q;
   logic [DATA_W-1:0]  rsp_data_d;
   req_id_t            rsp_id_q;
   req_id_t            rsp_id_d;

   logic               load;
   logic               grant_vld;
   req_id_t            grant_id;
   logic               accept;
   logic [DATA_W-1:0]  op_data;
   logic [SHAMT_W-1:0] op_shamt;
   logic [DATA_W-1:0]  rot_data;

   // Pick the requester: a sole requester wins, a tie goes to the one not granted last.
   // No grant is possible while reset is asserted.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = ~last_grant_q;
      end else if (bus.req0_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = 1'b1;
      end else begin
         grant_vld = 1'b0;
         grant_id  = 1'b0;
      end
      load   = !rst && ((state_q == EMPTY) || bus.rsp_ready);
      accept = load && grant_vld;
   end

   // Steer the granted operand into the shared rotator.
   always_comb begin
      op_data  = bus.req0_d_in;
      op_shamt = bus.req0_n_bits;
      if (grant_id == 1'b1) begin
         op_data  = bus.req1_d_in;
         op_shamt = bus.req1_n_bits;
      end else begin
         op_data  = bus.req0_d_in;
         op_shamt = bus.req0_n_bits;
      end
   end

   rotr8 u_rotr8 (
      .d_in   (op_data),
      .n_bits (op_shamt),
      .d_out  (rot_data)
   );

   // Slot next-state, captured result and round-robin pointer.
   always_comb begin
      state_d      = state_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
            end else begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (bus.rsp_ready && !accept) begin
               state_d = EMPTY;
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (accept) begin
         rsp_data_d   = rot_data;
         rsp_id_d     = grant_id;
         last_grant_d = grant_id;
      end else begin
         rsp_data_d   = rsp_data_q;
         rsp_id_d     = rsp_id_q;
         last_grant_d = last_grant_q;
      end
   end

   // State registers; reset empties the slot and lets requester 0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         rsp_data_q   <= 8'h00;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.req0_ready = accept && (grant_id == 1'b0);
   assign bus.req1_ready = accept && (grant_id == 1'b1);
   assign bus.rsp_valid  = (state_q == FULL);
   assign bus.rsp_d_out  = rsp_data_q;
   assign bus.rsp_id     = rsp_id_q;

endmodule : rotate_arbiter

// File: tb/tb_rotate_arbiter.sv
// Self-checking bench for rotate_arbiter with a behavioural slot/arbiter model.
module tb_rotate_arbiter;
   import rot_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rotate_arbiter_if bus ();

   rotate_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: one result slot and the winner of the last grant.
   bit         m_valid;
   logic [7:0] m_data;
   bit         m_id;
   bit         m_last;

   function automatic logic [7:0] m_rotr(input logic [7:0] x, input int n);
      logic [15:0] w;
      w = {x, x} >> n;
      return w[7:0];
   endfunction

   // Which requester the model would accept now (bit x = requester x ready).
   function automatic logic [1:0] m_ready();
      bit can_take;
      can_take = !m_valid || (bus.rsp_ready == 1'b1);
      if (rst || !can_take) return 2'b00;
      if (bus.req0_valid && bus.req1_valid) return (m_last == 1'b1) ? 2'b01 : 2'b10;
      if (bus.req0_valid) return 2'b01;
      if (bus.req1_valid) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = 8'h00; m_id = 1'b0; m_last = 1'b1;
   endtask

   // Advance one clock edge, updating the model with the inputs present at the edge.
   task automatic tick();
      logic [1:0] r;
      @(posedge clk);
      r = m_ready();
      if (rst) begin
         model_reset();
      end else if (r[0]) begin
         m_valid = 1'b1; m_data = m_rotr(bus.req0_d_in, int'(bus.req0_n_bits)); m_id = 1'b0; m_last = 1'b0;
      end else if (r[1]) begin
         m_valid = 1'b1; m_data = m_rotr(bus.req1_d_in, int'(bus.req1_n_bits)); m_id = 1'b1; m_last = 1'b1;
      end else if (m_valid && bus.rsp_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic drive(input bit v0, input logic [7:0] d0, input logic [2:0] n0,
                        input bit v1, input logic [7:0] d1, input logic [2:0] n1, input bit rr);
      bus.req0_valid = v0; bus.req0_d_in = d0; bus.req0_n_bits = n0;
      bus.req1_valid = v1; bus.req1_d_in = d1; bus.req1_n_bits = n1;
      bus.rsp_ready  = rr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(1'b1, 8'hFF, 3'd1, 1'b1, 8'hFF, 3'd2, 1'b1);
      rst = 1'b1;
      model_reset();
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_d_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.rsp_d_out); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_id: got %b want 0", bus.rsp_id); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_accept: got %b want 0", bus.rsp_valid); end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      rst = 1'b0;
   endtask

   task automatic test_single();
      drive(1'b1, 8'h81, 3'd1, 1'b0, 8'h00, 3'd0, 1'b1);
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
      tick();
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_d_out !== 8'hC0) begin n_err++; $display("FAIL single_data: got %h want c0", bus.rsp_d_out); end
      n_cmp++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL single_id: got %b want 0", bus.rsp_id); end
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", bus.rsp_valid); end
   endtask

   task automatic test_rotation_sweep();
      logic [7:0] tbl [8];
      tbl = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
      for (int n = 0; n < 8; n++) begin
         drive(1'b0, 8'h00, 3'd0, 1'b1, 8'h01, 3'(n), 1'b1);
         tick();
         n_cmp++; if (bus.rsp_d_out !== tbl[n] || bus.rsp_id !== 1'b1 || bus.rsp_valid !== 1'b1)
            begin n_err++; $display("FAIL sweep_n%0d: got v%b id%b %h want v1 id1 %h", n, bus.rsp_valid, bus.rsp_id, bus.rsp_d_out, tbl[n]); end
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      tick();
   endtask

   task automatic test_tie();
      do_reset();
      drive(1'b1, 8'h0F, 3'd4, 1'b1, 8'hF0, 3'd4, 1'b1);
      #1;
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_err++; $display("FAIL tie_first_ready: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
      tick();
      n_cmp++; if (bus.rsp_d_out !== 8'hF0 || bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL tie_first: got %h id%b want f0 id0", bus.rsp_d_out, bus.rsp_id); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_err++; $display("FAIL tie_second_ready: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
      tick();
      n_cmp++; if (bus.rsp_d_out !== 8'h0F || bus.rsp_id !== 1'b1) begin n_err++; $display("FAIL tie_second: got %h id%b want 0f id1", bus.rsp_d_out, bus.rsp_id); end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      tick();
   endtask

   task automatic test_backpressure();
      logic [7:0] hold_d;
      bit         hold_id;
      drive(1'b0, 8'h00, 3'd0, 1'b1, 8'hA5, 3'd3, 1'b1);
      tick();
      hold_d = m_data; hold_id = m_id;
      drive(1'b1, 8'h55, 3'd1, 1'b1, 8'h33, 3'd2, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready_c%0d: got %b want 00", k, {bus.req1_ready, bus.req0_ready}); end
         n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_d_out !== hold_d || bus.rsp_id !== hold_id)
            begin n_err++; $display("FAIL bp_hold_c%0d: got v%b %h id%b want v1 %h id%b", k, bus.rsp_valid, bus.rsp_d_out, bus.rsp_id, hold_d, hold_id); end
         tick();
      end
      drive(1'b1, 8'h55, 3'd1, 1'b0, 8'h00, 3'd0, 1'b1);
      #1;
      n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_passthru_ready: got %b want 1", bus.req0_ready); end
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_d_out !== 8'hAA || bus.rsp_id !== 1'b0)
         begin n_err++; $display("FAIL bp_passthru: got v%b %h id%b want v1 aa id0", bus.rsp_valid, bus.rsp_d_out, bus.rsp_id); end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      tick();
   endtask

   task automatic test_contention();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 8'($urandom), 3'($urandom), 1'b1, 8'($urandom), 3'($urandom), 1'b1);
         tick();
         n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(k % 2) || bus.rsp_d_out !== m_data)
            begin n_err++; $display("FAIL contend_c%0d: got v%b id%b %h want v1 id%0d %h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_d_out, k % 2, m_data); end
      end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      tick();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'h3C, 3'd2, 1'b0, 8'h00, 3'd0, 1'b0);
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL arst_fill: got %b want 1", bus.rsp_valid); end
      drive(1'b1, 8'h3C, 3'd2, 1'b1, 8'hC3, 3'd1, 1'b1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_d_out !== 8'h00) begin n_err++; $display("FAIL arst_drop: got v%b %h want v0 00", bus.rsp_valid, bus.rsp_d_out); end
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL arst_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
      tick();
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_no_accept: got %b want 0", bus.rsp_valid); end
      rst = 1'b0;
      tick();
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_d_out !== 8'h0F)
         begin n_err++; $display("FAIL arst_first_accept: got v%b id%b %h want v1 id0 0f", bus.rsp_valid, bus.rsp_id, bus.rsp_d_out); end
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      logic [1:0] er;
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 8'($urandom), 3'($urandom),
               ($urandom_range(0, 3) != 0));
         #1;
         er = m_ready();
         n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== er) begin n_err++; $display("FAIL rand_ready_c%0d: got %b want %b", k, {bus.req1_ready, bus.req0_ready}, er); end
         tick();
         n_cmp++; if (bus.rsp_valid !== m_valid) begin n_err++; $display("FAIL rand_valid_c%0d: got %b want %b", k, bus.rsp_valid, m_valid); end
         if (m_valid) begin
            n_cmp++; if (bus.rsp_d_out !== m_data || bus.rsp_id !== m_id)
               begin n_err++; $display("FAIL rand_rsp_c%0d: got %h id%b want %h id%b", k, bus.rsp_d_out, bus.rsp_id, m_data, m_id); end
         end
      end
   endtask

   initial begin
      drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1);
      model_reset();
      test_reset();
      test_single();
      test_rotation_sweep();
      test_tie();
      test_backpressure();
      test_contention();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_rotate_arbiter

// File: doc/rotate_arbiter.md
# rotate_arbiter

Shares one 8-bit rotate-right datapath between two requesters. Round-robin arbitration selects one requester per cycle, and the selected operand is rotated right by its 3-bit amount. The result is registered into a single response slot with a valid/ready handshake and a requester tag. The block sits between two producer ports and one consumer, replacing per-requester rotator instances.

## Interface
- `DATA_W`, 8, data width; only 8 is supported.
- `SHAMT_W`, 3, rotate-amount width; equals log2(DATA_W).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_d_in`  in  8  requester 0 operand.
- `req0_n_bits`  in  3  requester 0 rotate-right amount.
- `req1_valid`, `req1_ready`, `req1_d_in`, `req1_n_bits`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  response slot holds a result.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_d_out`  out  8  rotated result.
- `rsp_id`  out  1  index of the requester that produced the result.

## Operation
- Rotation: `rsp_d_out` = operand rotated right by `n_bits`. Bit i moves to bit (i − n) mod 8. `n_bits` = 0 passes the operand unchanged.
- Response slot FSM, two states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- `load` = EMPTY, or (FULL and `rsp_ready`).
- Transitions:
  - EMPTY→FULL on an accept.
  - FULL→EMPTY on `rsp_ready` with no accept.
  - FULL→FULL on `rsp_ready` with an accept (pass-through), or on `!rsp_ready` (hold).
- Arbitration:
  - Register `last_grant` (1 bit).
  - If only one `reqX_valid` is high, grant that requester.
  - If both are high, grant the requester ≠ `last_grant`.
  - If neither is high, no grant.
- `reqX_ready` = `load` AND grant==X. At most one ready is high per cycle.
- An accept happens when `reqX_valid` and `reqX_ready` are both high.
- On accept:
  - Slot loads the rotated data and `rsp_id`=X.
  - `last_grant` ← X.
- With no accept, `last_grant` is unchanged.
- While FULL and `!rsp_ready`:
  - `rsp_d_out` and `rsp_id` are held stable.
  - Both readies are 0.
- Fairness: with both requesters continuously valid and `rsp_ready`=1, grants strictly alternate. Neither requester waits more than one grant.
- Requesters may drop valid without being accepted. The arbiter holds no grant state beyond `last_grant`.

## Timing
- Reset values (async on `rst` rise, held while `rst`=1):
  - `rsp_valid`=0, `rsp_d_out`=8'h00, `rsp_id`=0, `last_grant`=1 (requester 0 wins first tie).
  - `req0_ready`=`req1_ready`=0.
- Latency: an accept at edge N gives `rsp_valid`=1 with the result after edge N. That is one cycle.
- Throughput: one operation per cycle while `rsp_ready`=1.
- `reqX_ready` is combinational from the valids, `rsp_ready` and state. It carries no registered delay.
- Reset asserted mid-operation discards any held response. No accept occurs on the edge where `rst` is high.
- After `rst` falls, the first accept is possible on the next rising edge.

## Structure
- Package `rot_arb_pkg`:
  - `DATA_W`, `SHAMT_W`.
  - `req_id_t` (1-bit requester index).
  - `slot_state_t` enum {EMPTY, FULL}.
- Sub-module `rotr8`: purely combinational 3-stage rotate (1/2/4 stages), inputs `d_in[7:0]` and `n_bits[2:0]`, output `d_out[7:0]`. Instantiated once after the operand mux.

## Test plan
- Reset then single request: `req0` 8'h81, n=1, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_d_out`=8'hC0, `rsp_id`=0.
- Rotation sweep: `req1` 8'h01 with n=0..7 → outputs 01, 80, 40, 20, 10, 08, 04, 02, each with `rsp_id`=1.
- Tie after reset: both valid (`req0` 8'h0F n=4, `req1` 8'hF0 n=4) → `req0` granted first (8'hF0, id 0), then `req1` (8'h0F, id 1).
- Backpressure: slot FULL with `rsp_ready`=0 for 3 cycles:
  - Output stays stable and both readies are 0.
  - Raising `rsp_ready` with `req0` pending gives a same-cycle pass-through accept.
- Sustained contention: both valid for 8 cycles, `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1,0,1,0,1 with one result per cycle.
- Async reset mid-stream: assert `rst` between edges while FULL → `rsp_valid` drops to 0 immediately and no accept occurs during reset.
